// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin burst arbiter with a registered output stage.
// A grant is held for one burst, which ends on last or after MAX_BURST beats.
module mux2_rr_arbiter #(
  parameter int BITWIDTH  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s1_valid,
  input  logic [BITWIDTH-1:0] s1_data,
  input  logic                s1_last,
  output logic                s1_ready,
  input  logic                s0_valid,
  input  logic [BITWIDTH-1:0] s0_data,
  input  logic                s0_last,
  output logic                s0_ready,
  output logic                m_valid,
  output logic [BITWIDTH-1:0] m_data,
  input  logic                m_ready,
  output logic                sel,
  output logic                busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [8:0] MAX_B9 = 9'(MAX_BURST);

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  last_served_q, last_served_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [BITWIDTH-1:0]   m_data_q, m_data_d;

  logic                  out_free;
  logic                  g_valid;
  logic                  g_last;
  logic [BITWIDTH-1:0]   g_data;
  logic                  xfer;
  logic [8:0]            cnt_inc;
  logic                  burst_end;

  // The output register can take a new beat when empty or being popped.
  assign out_free  = !m_valid_q || m_ready;
  assign g_valid   = sel_q ? s1_valid : s0_valid;
  assign g_last    = sel_q ? s1_last  : s0_last;
  assign g_data    = sel_q ? s1_data  : s0_data;
  assign xfer      = (state_q == GRANT) && g_valid && out_free;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign burst_end = xfer && (g_last || (cnt_inc == MAX_B9));

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_served_d = last_served_q;
    cnt_d         = cnt_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    s1_ready      = 1'b0;
    s0_ready      = 1'b0;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (s1_valid || s0_valid) begin
          state_d = GRANT;
          cnt_d   = 8'd0;
          // On a tie the source that did not own the previous burst wins.
          if (s1_valid && s0_valid) begin
            sel_d = !last_served_q;
          end else begin
            sel_d = s1_valid;
          end
        end
      end
      GRANT: begin
        s1_ready = sel_q && out_free;
        s0_ready = !sel_q && out_free;
        if (xfer) begin
          m_valid_d = 1'b1;
          m_data_d  = g_data;
          cnt_d     = cnt_inc[8] ? cnt_q : cnt_inc[7:0];
        end
        if (burst_end) begin
          state_d       = IDLE;
          last_served_d = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      last_served_q <= 1'b1;
      cnt_q         <= 8'd0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign sel     = sel_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: vector table, directed corner sequences and a
// random run, all checked against a transaction-level model of the arbiter.
module tb_mux2_rr_arbiter;

  localparam int MAXB = 4;

  logic       clk;
  logic       rst_n;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] s1_data;
  logic       s0_valid, s0_last, s0_ready;
  logic [7:0] s0_data;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       sel, busy;

  mux2_rr_arbiter #(.BITWIDTH(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .sel(sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who owns the datapath, beats taken, output slot contents.
  logic       mb, ms, mls, mmv;
  logic [7:0] mmd;
  int         mcnt;
  logic [7:0] outl[$];

  always @(negedge clk) begin
    logic free, gv, gl;
    logic [7:0] gd;
    if (!rst_n) begin
      mb = 1'b0; ms = 1'b0; mls = 1'b1; mmv = 1'b0; mmd = 8'h00; mcnt = 0;
    end else begin
      free = !mmv || m_ready;
      chk("mdl_busy", busy, mb);
      chk("mdl_sel", sel, ms);
      chk("mdl_s1_ready", s1_ready, mb && ms && free);
      chk("mdl_s0_ready", s0_ready, mb && !ms && free);
      chk("mdl_m_valid", m_valid, mmv);
      chk("mdl_m_data", m_data, mmd);
      if (m_valid && m_ready) outl.push_back(m_data);
      if (mb) begin
        gv = ms ? s1_valid : s0_valid;
        gl = ms ? s1_last  : s0_last;
        gd = ms ? s1_data  : s0_data;
        if (gv && free) begin
          mmv = 1'b1; mmd = gd; mcnt++;
          if (gl || mcnt == MAXB) begin mb = 1'b0; mls = ms; end
        end else if (mmv && m_ready) begin
          mmv = 1'b0;
        end
      end else begin
        if (mmv && m_ready) mmv = 1'b0;
        if (s1_valid || s0_valid) begin
          mb = 1'b1; mcnt = 0;
          ms = (s1_valid && s0_valid) ? !mls : s1_valid;
        end
      end
    end
  end

  // Directed-sequence source feeders: {last, data} per queued beat.
  logic [8:0] s1q[$], s0q[$];
  logic       en1, en0, hold1, hold0;
  logic [7:0] expq[$];

  task automatic drive_srcs();
    s1_valid = en1 && !hold1 && (s1q.size() != 0);
    s1_data  = (s1q.size() != 0) ? s1q[0][7:0] : 8'h00;
    s1_last  = (s1q.size() != 0) ? s1q[0][8]   : 1'b0;
    s0_valid = en0 && !hold0 && (s0q.size() != 0);
    s0_data  = (s0q.size() != 0) ? s0q[0][7:0] : 8'h00;
    s0_last  = (s0q.size() != 0) ? s0q[0][8]   : 1'b0;
  endtask

  task automatic cycle_edge();
    @(negedge clk);
    if (s1_valid && s1_ready && s1q.size() != 0) void'(s1q.pop_front());
    if (s0_valid && s0_ready && s0q.size() != 0) void'(s0q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_count"}, outl.size(), expq.size());
    for (int k = 0; k < expq.size(); k++) begin
      chk($sformatf("%s_beat%0d", nm, k), (k < outl.size()) ? outl[k] : 8'hxx, expq[k]);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       s1v; logic [7:0] s1d; logic s1l;
    logic       s0v; logic [7:0] s0d; logic s0l;
    logic       mr;
    logic       busy; logic sel; logic r1; logic r0; logic mv; logic [7:0] md;
  } vec_t;

  vec_t vec[14];
  logic [7:0] held;

  initial begin
    rst_n = 1'b0; m_ready = 1'b1;
    en1 = 1'b0; en0 = 1'b0; hold1 = 1'b0; hold0 = 1'b0;
    drive_srcs();

    //           rst s1v s1d    s1l s0v s0d    s0l mr  busy sel r1 r0 mv md
    vec[0]  = '{1'b1,1'b1,8'hA5,1'b1,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vec[1]  = '{1'b1,1'b1,8'hA5,1'b1,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b0,1'b0,8'h00};
    vec[2]  = '{1'b1,1'b0,8'hA5,1'b1,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1,8'hA5};
    vec[3]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vec[4]  = '{1'b1,1'b1,8'h21,1'b1,1'b1,8'h31,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vec[5]  = '{1'b1,1'b1,8'h21,1'b1,1'b1,8'h31,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h00};
    vec[6]  = '{1'b1,1'b1,8'h21,1'b1,1'b1,8'h31,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,8'h31};
    vec[7]  = '{1'b1,1'b1,8'h21,1'b1,1'b1,8'h31,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0,1'b0,8'h31};
    vec[8]  = '{1'b1,1'b1,8'h21,1'b1,1'b1,8'h32,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1,8'h21};
    vec[9]  = '{1'b1,1'b1,8'h21,1'b1,1'b1,8'h32,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h21};
    vec[10] = '{1'b1,1'b1,8'h22,1'b1,1'b1,8'h32,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,8'h32};
    vec[11] = '{1'b1,1'b1,8'h22,1'b1,1'b1,8'h32,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0,1'b0,8'h32};
    vec[12] = '{1'b1,1'b0,8'h22,1'b1,1'b0,8'h32,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1,8'h22};
    vec[13] = '{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0,8'h22};

    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 14; r++) begin
      rst_n    = vec[r].rst;
      s1_valid = vec[r].s1v; s1_data = vec[r].s1d; s1_last = vec[r].s1l;
      s0_valid = vec[r].s0v; s0_data = vec[r].s0d; s0_last = vec[r].s0l;
      m_ready  = vec[r].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", r), busy, vec[r].busy);
      chk($sformatf("tbl%0d_sel", r), sel, vec[r].sel);
      chk($sformatf("tbl%0d_s1_ready", r), s1_ready, vec[r].r1);
      chk($sformatf("tbl%0d_s0_ready", r), s0_ready, vec[r].r0);
      chk($sformatf("tbl%0d_m_valid", r), m_valid, vec[r].mv);
      chk($sformatf("tbl%0d_m_data", r), m_data, vec[r].md);
      @(posedge clk);
      #1;
    end

    // Burst cap: route 1 alone first, route 0 joins; cap splits route 1.
    outl.delete(); m_ready = 1'b1;
    s1q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
    s0q = '{9'h040, 9'h141};
    en1 = 1'b1; en0 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) en0 = 1'b1;
      drive_srcs();
      cycle_edge();
    end
    expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h40, 8'h41, 8'h05, 8'h06};
    check_log("cap");

    // Early last on route 0 hands over to route 1.
    outl.delete();
    s0q = '{9'h010, 9'h111, 9'h112};
    s1q = '{9'h150};
    for (int i = 0; i < 10; i++) begin
      drive_srcs();
      cycle_edge();
    end
    expq = '{8'h10, 8'h11, 8'h50, 8'h12};
    check_log("early");

    // Backpressure during a route 1 burst.
    outl.delete(); en0 = 1'b0;
    s1q = '{9'h060, 9'h061, 9'h062, 9'h163};
    for (int i = 0; i < 12; i++) begin
      m_ready = !(i >= 3 && i <= 5);
      drive_srcs();
      #1;
      if (i >= 3 && i <= 5) begin
        chk("bp_m_valid", m_valid, 1'b1);
        chk("bp_s1_ready", s1_ready, 1'b0);
        if (i == 3) held = m_data;
        else chk("bp_m_data_hold", m_data, held);
      end
      cycle_edge();
    end
    expq = '{8'h60, 8'h61, 8'h62, 8'h63};
    check_log("bp");

    // Route 0 stalls mid-burst; route 1 must wait.
    outl.delete(); m_ready = 1'b1; en0 = 1'b1;
    s0q = '{9'h070, 9'h071, 9'h172};
    s1q = '{9'h180};
    for (int i = 0; i < 14; i++) begin
      hold0 = (i >= 3 && i < 8);
      drive_srcs();
      #1;
      if (hold0) begin
        chk("stall_busy", busy, 1'b1);
        chk("stall_sel", sel, 1'b0);
        chk("stall_s1_ready", s1_ready, 1'b0);
      end
      cycle_edge();
    end
    hold0 = 1'b0;
    expq = '{8'h70, 8'h71, 8'h72, 8'h80};
    check_log("stall");

    // Reset mid-burst with a beat parked in the output register.
    en0 = 1'b0; en1 = 1'b1;
    s1q = '{9'h090, 9'h091, 9'h092, 9'h193};
    drive_srcs(); cycle_edge();
    drive_srcs(); cycle_edge();
    m_ready = 1'b0;
    drive_srcs();
    #1;
    chk("rst_pre_m_valid", m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_sel", sel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s1_ready", s1_ready, 1'b0);
    chk("rst_s0_ready", s0_ready, 1'b0);
    s1q.delete(); m_ready = 1'b1;
    drive_srcs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    s1q = '{9'h1A5};
    drive_srcs();
    #1;
    chk("post_rst_busy", busy, 1'b0);
    cycle_edge();
    chk("post_rst_sel", sel, 1'b1);
    chk("post_rst_busy1", busy, 1'b1);
    cycle_edge();
    chk("post_rst_m_valid", m_valid, 1'b1);
    chk("post_rst_m_data", m_data, 8'hA5);
    drive_srcs();
    repeat (3) cycle_edge();

    // Random traffic against the model.
    en1 = 1'b0; en0 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      s1_valid = ($urandom % 4) != 0;
      s1_data  = 8'($urandom);
      s1_last  = ($urandom % 3) == 0;
      s0_valid = ($urandom % 4) != 0;
      s0_data  = 8'($urandom);
      s0_last  = ($urandom % 3) == 0;
      m_ready  = ($urandom % 4) != 0;
      cycle_edge();
    end
    s1_valid = 1'b0; s0_valid = 1'b0; m_ready = 1'b1;
    repeat (4) cycle_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
